// File: rtl/spi_arbiter.sv
// ============================================================================
// spi_arbiter : round-robin sharing of one SPI interface between two ports,
//               with per-transaction grant hold and a timeout watchdog.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module spi_arbiter #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 64,
  parameter int TMO_W   = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_in,
  input  logic              we0_in,
  input  logic [DATA_W-1:0] wdata0_in,
  output logic              ack0_out,
  output logic              err0_out,
  output logic [DATA_W-1:0] rdata0_out,
  input  logic              req1_in,
  input  logic              we1_in,
  input  logic [DATA_W-1:0] wdata1_in,
  output logic              ack1_out,
  output logic              err1_out,
  output logic [DATA_W-1:0] rdata1_out,
  output logic              spi_read_out,
  output logic              spi_send_out,
  output logic [DATA_W-1:0] spi_data_out,
  input  logic [DATA_W-1:0] spi_data_in,
  input  logic              spi_ready_in,
  output logic              spi_rst_out,
  output logic              busy_out,
  output logic              grant_out
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_ABORT = 3'd4
  } state_t;

  localparam logic [TMO_W-1:0] C_TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              grant_q, grant_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [TMO_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= 1'b1;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      ST_IDLE: begin
        if (req0_in || req1_in) begin
          // On a tie the port that did not own the bus last goes next.
          grant_d = (req0_in && req1_in) ? ~grant_q : req1_in;
          we_d    = grant_d ? we1_in : we0_in;
          wdata_d = grant_d ? wdata1_in : wdata0_in;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + TMO_W'(1);
        if (spi_ready_in) begin
          if (grant_q) rdata1_d = spi_data_in;
          else         rdata0_d = spi_data_in;
          state_d = ST_RESP;
        end else if (cnt_q == C_TMO_LAST) begin
          state_d = ST_ABORT;
        end
      end
      ST_RESP:  state_d = ST_IDLE;
      ST_ABORT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs are masked while rst is high so nothing leaks out of a reset cycle.
  logic w_done;
  logic w_abort;
  assign w_done  = ~rst && ((state_q == ST_RESP) || (state_q == ST_ABORT));
  assign w_abort = ~rst && (state_q == ST_ABORT);

  assign spi_send_out = ~rst && (state_q == ST_ISSUE) &&  we_q;
  assign spi_read_out = ~rst && (state_q == ST_ISSUE) && ~we_q;
  assign spi_rst_out  = rst || (state_q == ST_ABORT);
  assign spi_data_out = wdata_q;
  assign ack0_out     = w_done  && ~grant_q;
  assign ack1_out     = w_done  &&  grant_q;
  assign err0_out     = w_abort && ~grant_q;
  assign err1_out     = w_abort &&  grant_q;
  assign rdata0_out   = rdata0_q;
  assign rdata1_out   = rdata1_q;
  assign busy_out     = ~rst && (state_q != ST_IDLE);
  assign grant_out    = grant_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_arbiter.sv
// Directed self-checking bench for spi_arbiter.
`default_nettype none

module tb_spi_arbiter;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 64;
  localparam int TMO_W   = 7;

  logic              clk = 1'b0;
  logic              rst;
  logic              req0_in, we0_in, req1_in, we1_in;
  logic [DATA_W-1:0] wdata0_in, wdata1_in;
  logic              ack0_out, err0_out, ack1_out, err1_out;
  logic [DATA_W-1:0] rdata0_out, rdata1_out;
  logic              spi_read_out, spi_send_out, spi_rst_out;
  logic [DATA_W-1:0] spi_data_out, spi_data_in;
  logic              spi_ready_in;
  logic              busy_out, grant_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  spi_arbiter #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .TMO_W(TMO_W)) dut (
    .clk(clk), .rst(rst),
    .req0_in(req0_in), .we0_in(we0_in), .wdata0_in(wdata0_in),
    .ack0_out(ack0_out), .err0_out(err0_out), .rdata0_out(rdata0_out),
    .req1_in(req1_in), .we1_in(we1_in), .wdata1_in(wdata1_in),
    .ack1_out(ack1_out), .err1_out(err1_out), .rdata1_out(rdata1_out),
    .spi_read_out(spi_read_out), .spi_send_out(spi_send_out),
    .spi_data_out(spi_data_out), .spi_data_in(spi_data_in),
    .spi_ready_in(spi_ready_in), .spi_rst_out(spi_rst_out),
    .busy_out(busy_out), .grant_out(grant_out)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    total++;
    if ({ack0_out, ack1_out, err0_out, err1_out} !== 4'b0000) begin
      bad++; $display("FAIL reset_ack: ack0=%b ack1=%b err0=%b err1=%b want 0", ack0_out, ack1_out, err0_out, err1_out);
    end
    total++;
    if ({spi_read_out, spi_send_out, busy_out} !== 3'b000) begin
      bad++; $display("FAIL reset_strobe: read=%b send=%b busy=%b want 0", spi_read_out, spi_send_out, busy_out);
    end
    total++;
    if (spi_rst_out !== 1'b1 || grant_out !== 1'b1) begin
      bad++; $display("FAIL reset_rst_grant: spi_rst=%b grant=%b want 1 1", spi_rst_out, grant_out);
    end
    total++;
    if (spi_data_out !== 8'h00 || rdata0_out !== 8'h00 || rdata1_out !== 8'h00) begin
      bad++; $display("FAIL reset_data: spi_data=%h rdata0=%h rdata1=%h want 00", spi_data_out, rdata0_out, rdata1_out);
    end
    rst = 1'b0;
    tick();
    total++;
    if (spi_rst_out !== 1'b0) begin
      bad++; $display("FAIL reset_release: spi_rst=%b want 0", spi_rst_out);
    end
  endtask

  task automatic test_single_read;
    int extra;
    extra = 0;
    req0_in = 1'b1; we0_in = 1'b0; wdata0_in = 8'hFF;
    tick();
    total++;
    if (spi_read_out !== 1'b1 || spi_send_out !== 1'b0 || grant_out !== 1'b0 || busy_out !== 1'b1) begin
      bad++; $display("FAIL read_strobe: read=%b send=%b grant=%b busy=%b want 1 0 0 1", spi_read_out, spi_send_out, grant_out, busy_out);
    end
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (spi_read_out || spi_send_out || ack0_out || ack1_out) extra++;
    end
    spi_ready_in = 1'b1; spi_data_in = 8'hA5;
    tick();
    spi_ready_in = 1'b0; spi_data_in = 8'h00;
    total++;
    if (ack0_out !== 1'b1 || err0_out !== 1'b0 || ack1_out !== 1'b0 || rdata0_out !== 8'hA5) begin
      bad++; $display("FAIL read_ack: ack0=%b err0=%b ack1=%b rdata0=%h want 1 0 0 a5", ack0_out, err0_out, ack1_out, rdata0_out);
    end
    total++;
    if (extra !== 0) begin
      bad++; $display("FAIL read_quiet: %0d stray strobe/ack cycles want 0", extra);
    end
    req0_in = 1'b0;
    tick();
    total++;
    if (ack0_out !== 1'b0 || busy_out !== 1'b0 || rdata0_out !== 8'hA5) begin
      bad++; $display("FAIL read_idle: ack0=%b busy=%b rdata0=%h want 0 0 a5", ack0_out, busy_out, rdata0_out);
    end
  endtask

  task automatic test_single_write;
    int held_bad;
    held_bad = 0;
    req1_in = 1'b1; we1_in = 1'b1; wdata1_in = 8'h3C;
    tick();
    total++;
    if (spi_send_out !== 1'b1 || spi_read_out !== 1'b0 || grant_out !== 1'b1 || spi_data_out !== 8'h3C) begin
      bad++; $display("FAIL write_strobe: send=%b read=%b grant=%b data=%h want 1 0 1 3c", spi_send_out, spi_read_out, grant_out, spi_data_out);
    end
    for (int i = 1; i <= 3; i++) begin
      tick();
      if (spi_data_out !== 8'h3C || spi_send_out !== 1'b0 || ack0_out !== 1'b0) held_bad++;
    end
    total++;
    if (held_bad !== 0) begin
      bad++; $display("FAIL write_hold: %0d bad WAIT cycles want 0", held_bad);
    end
    spi_ready_in = 1'b1; spi_data_in = 8'h77;
    tick();
    spi_ready_in = 1'b0;
    total++;
    if (ack1_out !== 1'b1 || err1_out !== 1'b0 || ack0_out !== 1'b0 || rdata1_out !== 8'h77 || spi_data_out !== 8'h3C) begin
      bad++; $display("FAIL write_ack: ack1=%b err1=%b ack0=%b rdata1=%h data=%h want 1 0 0 77 3c", ack1_out, err1_out, ack0_out, rdata1_out, spi_data_out);
    end
    req1_in = 1'b0;
    tick();
  endtask

  task automatic test_spurious_ready;
    spi_ready_in = 1'b1; spi_data_in = 8'hEE;
    tick();
    tick();
    spi_ready_in = 1'b0;
    total++;
    if (busy_out !== 1'b0 || ack0_out !== 1'b0 || ack1_out !== 1'b0 || rdata0_out !== 8'hA5 || rdata1_out !== 8'h77) begin
      bad++; $display("FAIL spurious_ready: busy=%b ack0=%b ack1=%b rdata0=%h rdata1=%h want 0 0 0 a5 77", busy_out, ack0_out, ack1_out, rdata0_out, rdata1_out);
    end
  endtask

  task automatic test_contention;
    logic exp;
    int   cyc;
    int   stray;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req0_in = 1'b1; we0_in = 1'b0; wdata0_in = 8'h11;
    req1_in = 1'b1; we1_in = 1'b1; wdata1_in = 8'h22;
    exp = 1'b0;
    for (int t = 0; t < 4; t++) begin
      cyc = 0;
      stray = 0;
      do begin
        tick();
        cyc++;
      end while (!(spi_read_out || spi_send_out) && cyc < 20);
      total++;
      if (cyc !== 1) begin
        bad++; $display("FAIL contention_latency[%0d]: strobe after %0d cycles want 1", t, cyc);
      end
      total++;
      if (grant_out !== exp || spi_send_out !== exp || spi_read_out !== ~exp) begin
        bad++; $display("FAIL contention_grant[%0d]: grant=%b send=%b read=%b want grant %b", t, grant_out, spi_send_out, spi_read_out, exp);
      end
      for (int i = 0; i < 2; i++) begin
        tick();
        if (spi_read_out || spi_send_out) stray++;
      end
      spi_ready_in = 1'b1; spi_data_in = 8'h40 + 8'(t);
      tick();
      spi_ready_in = 1'b0;
      total++;
      if (ack0_out !== ~exp || ack1_out !== exp || stray !== 0) begin
        bad++; $display("FAIL contention_ack[%0d]: ack0=%b ack1=%b stray=%0d want owner %b only", t, ack0_out, ack1_out, stray, exp);
      end
      if (exp) req1_in = 1'b0; else req0_in = 1'b0;
      tick();
      if (exp) req1_in = 1'b1; else req0_in = 1'b1;
      exp = ~exp;
    end
    req0_in = 1'b0; req1_in = 1'b0;
    tick();
  endtask

  task automatic test_timeout;
    logic [DATA_W-1:0] r0;
    int cyc;
    int early;
    early = 0;
    r0 = rdata0_out;
    req0_in = 1'b1; we0_in = 1'b0;
    tick();
    total++;
    if (spi_read_out !== 1'b1) begin
      bad++; $display("FAIL timeout_strobe: read=%b want 1", spi_read_out);
    end
    cyc = 0;
    do begin
      tick();
      cyc++;
      if (spi_rst_out && !ack0_out) early++;
    end while (!ack0_out && cyc < 100);
    // WAIT holds counter values 0..63 in strobe+1..strobe+64; ABORT follows.
    total++;
    if (cyc !== TIMEOUT + 1) begin
      bad++; $display("FAIL timeout_latency: ack after %0d cycles want %0d", cyc, TIMEOUT + 1);
    end
    total++;
    if (err0_out !== 1'b1 || spi_rst_out !== 1'b1 || ack1_out !== 1'b0 || rdata0_out !== r0 || early !== 0) begin
      bad++; $display("FAIL timeout_abort: err0=%b spi_rst=%b ack1=%b rdata0=%h early=%0d want 1 1 0 %h 0", err0_out, spi_rst_out, ack1_out, rdata0_out, early, r0);
    end
    req0_in = 1'b0;
    tick();
    total++;
    if (spi_rst_out !== 1'b0 || busy_out !== 1'b0 || ack0_out !== 1'b0) begin
      bad++; $display("FAIL timeout_after: spi_rst=%b busy=%b ack0=%b want 0 0 0", spi_rst_out, busy_out, ack0_out);
    end
    req0_in = 1'b1;
    tick();
    tick();
    spi_ready_in = 1'b1; spi_data_in = 8'hC3;
    tick();
    spi_ready_in = 1'b0;
    total++;
    if (ack0_out !== 1'b1 || err0_out !== 1'b0 || rdata0_out !== 8'hC3) begin
      bad++; $display("FAIL timeout_recover: ack0=%b err0=%b rdata0=%h want 1 0 c3", ack0_out, err0_out, rdata0_out);
    end
    req0_in = 1'b0;
    tick();
  endtask

  task automatic test_ready_boundary;
    int early;
    early = 0;
    req1_in = 1'b1; we1_in = 1'b0;
    tick();
    for (int i = 1; i <= TIMEOUT; i++) begin
      tick();
      if (ack1_out || spi_rst_out) early++;
    end
    total++;
    if (busy_out !== 1'b1 || early !== 0) begin
      bad++; $display("FAIL boundary_wait: busy=%b early=%0d want 1 0", busy_out, early);
    end
    spi_ready_in = 1'b1; spi_data_in = 8'h5A;
    tick();
    spi_ready_in = 1'b0;
    total++;
    if (ack1_out !== 1'b1 || err1_out !== 1'b0 || rdata1_out !== 8'h5A || spi_rst_out !== 1'b0) begin
      bad++; $display("FAIL boundary_ack: ack1=%b err1=%b rdata1=%h spi_rst=%b want 1 0 5a 0", ack1_out, err1_out, rdata1_out, spi_rst_out);
    end
    req1_in = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_wait;
    req1_in = 1'b1; we1_in = 1'b1; wdata1_in = 8'h99;
    tick();
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    total++;
    if (spi_rst_out !== 1'b1 || busy_out !== 1'b0 || ack1_out !== 1'b0 || ack0_out !== 1'b0) begin
      bad++; $display("FAIL rstwait_during: spi_rst=%b busy=%b ack1=%b ack0=%b want 1 0 0 0", spi_rst_out, busy_out, ack1_out, ack0_out);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    total++;
    if (busy_out !== 1'b0 || ack1_out !== 1'b0 || spi_send_out !== 1'b0 || spi_rst_out !== 1'b0 || grant_out !== 1'b1) begin
      bad++; $display("FAIL rstwait_after: busy=%b ack1=%b send=%b spi_rst=%b grant=%b want 0 0 0 0 1", busy_out, ack1_out, spi_send_out, spi_rst_out, grant_out);
    end
    tick();
    total++;
    if (spi_send_out !== 1'b1 || grant_out !== 1'b1 || spi_data_out !== 8'h99) begin
      bad++; $display("FAIL rstwait_regrant: send=%b grant=%b data=%h want 1 1 99", spi_send_out, grant_out, spi_data_out);
    end
    tick();
    spi_ready_in = 1'b1; spi_data_in = 8'h01;
    tick();
    spi_ready_in = 1'b0;
    total++;
    if (ack1_out !== 1'b1 || err1_out !== 1'b0) begin
      bad++; $display("FAIL rstwait_ack: ack1=%b err1=%b want 1 0", ack1_out, err1_out);
    end
    req1_in = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    req0_in = 1'b0; we0_in = 1'b0; wdata0_in = '0;
    req1_in = 1'b0; we1_in = 1'b0; wdata1_in = '0;
    spi_ready_in = 1'b0; spi_data_in = '0;
    test_reset();
    test_single_read();
    test_single_write();
    test_spurious_ready();
    test_contention();
    test_timeout();
    test_ready_boundary();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
